// File: rtl/fb_pixel_sink.sv
// Plot-interface pixel sink: buffers pixel writes in a first-word-fall-through FIFO.
// It drains them to a valid/ready framebuffer port and can run a full-screen fill engine.
module fb_pixel_sink #(
    parameter int unsigned WIDTH    = 160,
    parameter int unsigned HEIGHT   = 120,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned COLOUR_W = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                x,
    input  logic [6:0]                y,
    input  logic [COLOUR_W-1:0]       colour,
    input  logic                      write_en,
    input  logic                      fill_req,
    input  logic [COLOUR_W-1:0]       fill_colour,
    output logic [ADDR_W-1:0]         fb_addr,
    output logic [COLOUR_W-1:0]       fb_data,
    output logic                      fb_wren,
    input  logic                      fb_ready,
    output logic                      fill_busy,
    output logic                      fill_done,
    output logic                      overflow,
    output logic                      oob,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_FILL_WAIT = 2'd1;
    localparam logic [1:0] ST_FILL      = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } entry_t;

    entry_t               mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [1:0]           state_q, state_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic [COLOUR_W-1:0]  fill_colour_q, fill_colour_d;
    logic                 fill_done_q, fill_done_d;
    logic                 overflow_q, oob_q;

    logic                 in_range, fifo_valid, full, push, pop, drop;
    entry_t               head, new_entry;

    assign in_range   = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
    assign new_entry  = '{addr: ADDR_W'(32'(y) * WIDTH + 32'(x)), colour: colour};
    assign head       = mem[rd_ptr_q];
    assign fifo_valid = (level_q != '0);
    assign full       = (level_q == LVL_W'(DEPTH));
    // The fill engine owns the port in FILL, so the FIFO head only drains in RUN/FILL_WAIT.
    assign pop        = (state_q != ST_FILL) && fifo_valid && fb_ready;
    assign push       = write_en && in_range && (!full || pop);
    assign drop       = write_en && in_range && full && !pop;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fill_colour_d = fill_colour_q;
        fill_done_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (fill_req) begin
                    fill_colour_d = fill_colour;
                    state_d       = ST_FILL_WAIT;
                end
            end
            ST_FILL_WAIT: begin
                if (!fifo_valid) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end
            end
            ST_FILL: begin
                if (fb_ready) begin
                    if (cnt_q == FILL_LAST) begin
                        state_d     = ST_RUN;
                        cnt_d       = '0;
                        fill_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            fill_colour_q <= '0;
            fill_done_q   <= 1'b0;
            overflow_q    <= 1'b0;
            oob_q         <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q       <= level_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fill_colour_q <= fill_colour_d;
            fill_done_q   <= fill_done_d;
            overflow_q    <= overflow_q | drop;
            oob_q         <= write_en && !in_range;
        end
    end

    // NOTE: the storage array has no reset; entries are only visible below level_q.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= new_entry;
    end

    always_comb begin
        fb_wren = 1'b0;
        fb_addr = '0;
        fb_data = '0;
        if (state_q == ST_FILL) begin
            fb_wren = 1'b1;
            fb_addr = cnt_q;
            fb_data = fill_colour_q;
        end else if (fifo_valid) begin
            fb_wren = 1'b1;
            fb_addr = head.addr;
            fb_data = head.colour;
        end
    end

    assign fill_busy = (state_q != ST_RUN);
    assign fill_done = fill_done_q;
    assign overflow  = overflow_q;
    assign oob       = oob_q;
    assign level     = level_q;

endmodule

// File: tb/tb_fb_pixel_sink.sv
// Directed bench for fb_pixel_sink: vector table for single-cycle behaviour,
// hand-written sequences for overflow, full-FIFO streaming, fill ordering and reset.
module tb_fb_pixel_sink;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [5:0]  colour;
    logic        write_en;
    logic        fill_req;
    logic [5:0]  fill_colour;
    logic [14:0] fb_addr;
    logic [5:0]  fb_data;
    logic        fb_wren;
    logic        fb_ready;
    logic        fill_busy;
    logic        fill_done;
    logic        overflow;
    logic        oob;
    logic [4:0]  level;

    int n_checks = 0;
    int n_errors = 0;

    fb_pixel_sink dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .colour(colour),
        .write_en(write_en), .fill_req(fill_req), .fill_colour(fill_colour),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_wren(fb_wren), .fb_ready(fb_ready),
        .fill_busy(fill_busy), .fill_done(fill_done), .overflow(overflow),
        .oob(oob), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [5:0]  col;
        logic        rdy;
        logic        e_wren;
        logic [14:0] e_addr;
        logic [5:0]  e_data;
        logic [4:0]  e_level;
        logic        e_oob;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Outputs are sampled 1ns after the active edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write_en = 1'b0; x = '0; y = '0; colour = '0;
        fill_req = 1'b0; fill_colour = '0; fb_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic put(input logic [7:0] px, input logic [6:0] py, input logic [5:0] pc);
        write_en = 1'b1; x = px; y = py; colour = pc;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'd3,   7'd2,   6'h15, 1'b1, 1'b1, 15'd323,   6'h15, 5'd1, 1'b0};
        vecs[1]  = '{1'b0, 8'd0,   7'd0,   6'h00, 1'b1, 1'b0, 15'd0,     6'h00, 5'd0, 1'b0};
        vecs[2]  = '{1'b1, 8'd160, 7'd0,   6'h11, 1'b1, 1'b0, 15'd0,     6'h00, 5'd0, 1'b1};
        vecs[3]  = '{1'b1, 8'd0,   7'd120, 6'h12, 1'b1, 1'b0, 15'd0,     6'h00, 5'd0, 1'b1};
        vecs[4]  = '{1'b0, 8'd0,   7'd0,   6'h00, 1'b1, 1'b0, 15'd0,     6'h00, 5'd0, 1'b0};
        vecs[5]  = '{1'b1, 8'd159, 7'd119, 6'h3f, 1'b1, 1'b1, 15'd19199, 6'h3f, 5'd1, 1'b0};
        vecs[6]  = '{1'b1, 8'd0,   7'd0,   6'h01, 1'b1, 1'b1, 15'd0,     6'h01, 5'd1, 1'b0};
        vecs[7]  = '{1'b0, 8'd0,   7'd0,   6'h00, 1'b0, 1'b1, 15'd0,     6'h01, 5'd1, 1'b0};
        vecs[8]  = '{1'b0, 8'd0,   7'd0,   6'h00, 1'b0, 1'b1, 15'd0,     6'h01, 5'd1, 1'b0};
        vecs[9]  = '{1'b0, 8'd0,   7'd0,   6'h00, 1'b1, 1'b0, 15'd0,     6'h00, 5'd0, 1'b0};
        vecs[10] = '{1'b1, 8'd255, 7'd127, 6'h2a, 1'b1, 1'b0, 15'd0,     6'h00, 5'd0, 1'b1};

        do_reset();
        check("rst_wren", 32'(fb_wren), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_busy", 32'(fill_busy), 32'(0));
        check("rst_done", 32'(fill_done), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_oob", 32'(oob), 32'(0));
        check("rst_addr", 32'(fb_addr), 32'(0));

        // Table: each vector is applied for one edge, then outputs are compared.
        for (int i = 0; i < NV; i++) begin
            write_en = vecs[i].we; x = vecs[i].x; y = vecs[i].y;
            colour = vecs[i].col; fb_ready = vecs[i].rdy;
            tick();
            check($sformatf("v%0d_wren", i), 32'(fb_wren), 32'(vecs[i].e_wren));
            check($sformatf("v%0d_addr", i), 32'(fb_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_data", i), 32'(fb_data), 32'(vecs[i].e_data));
            check($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_level));
            check($sformatf("v%0d_oob", i), 32'(oob), 32'(vecs[i].e_oob));
        end
        write_en = 1'b0;

        // Overflow: 17 writes into a stalled port, then drain in order.
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            put(8'(i), 7'd0, 6'(i));
            tick();
            if (i == 15) begin
                check("ovf_level16", 32'(level), 32'(16));
                check("ovf_not_yet", 32'(overflow), 32'(0));
            end
        end
        check("ovf_level_after17", 32'(level), 32'(16));
        check("ovf_set", 32'(overflow), 32'(1));
        write_en = 1'b0;
        fb_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf_beat%0d_wren", i), 32'(fb_wren), 32'(1));
            check($sformatf("ovf_beat%0d_addr", i), 32'(fb_addr), 32'(i));
            check($sformatf("ovf_beat%0d_data", i), 32'(fb_data), 32'(i));
            tick();
        end
        check("ovf_drained", 32'(level), 32'(0));
        check("ovf_sticky", 32'(overflow), 32'(1));

        // Full FIFO streaming: simultaneous push and pop never drops.
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            put(8'(i), 7'd1, 6'(i));
            tick();
        end
        fb_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            put(8'(16 + j), 7'd1, 6'(16 + j));
            check($sformatf("full_j%0d_level", j), 32'(level), 32'(16));
            check($sformatf("full_j%0d_addr", j), 32'(fb_addr), 32'(160 + j));
            tick();
        end
        write_en = 1'b0;
        check("full_level_end", 32'(level), 32'(16));
        check("full_no_overflow", 32'(overflow), 32'(0));
        for (int j = 0; j < 16; j++) tick();
        check("full_drained", 32'(level), 32'(0));

        // Fill after 3 queued writes, with one write injected mid-fill.
        do_reset();
        fb_ready = 1'b0;
        put(8'd10, 7'd0, 6'd5); tick();
        put(8'd11, 7'd0, 6'd6); tick();
        put(8'd12, 7'd0, 6'd7); tick();
        write_en = 1'b0;
        check("fill_pre_level", 32'(level), 32'(3));
        begin
            int b = 0;
            int n_bad = 0;
            int done_cnt = 0;
            bit injected = 1'b0;
            bit expect_done = 1'b0;
            logic [14:0] e_addr;
            logic [5:0]  e_data;
            for (int cyc = 0; cyc < 30000 && b < 19204; cyc++) begin
                fb_ready = 1'b1;
                fill_req = (cyc == 0);
                fill_colour = 6'h00;
                write_en = 1'b0;
                if (b == 103 && !injected) begin
                    put(8'd20, 7'd3, 6'h2a);
                    injected = 1'b1;
                end
                if (cyc == 1) check("fill_busy_set", 32'(fill_busy), 32'(1));
                if (expect_done) begin
                    check("fill_done_after_last", 32'(fill_done), 32'(1));
                    check("fill_busy_cleared", 32'(fill_busy), 32'(0));
                    expect_done = 1'b0;
                end
                if (fill_done) done_cnt++;
                if (fb_wren) begin
                    if (b < 3) begin
                        e_addr = 15'(10 + b); e_data = 6'(5 + b);
                    end else if (b < 19203) begin
                        e_addr = 15'(b - 3); e_data = 6'h00;
                    end else begin
                        e_addr = 15'd500; e_data = 6'h2a;
                    end
                    if (fb_addr !== e_addr || fb_data !== e_data) begin
                        if (n_bad < 4) begin
                            check($sformatf("fill_beat%0d_addr", b), 32'(fb_addr), 32'(e_addr));
                            check($sformatf("fill_beat%0d_data", b), 32'(fb_data), 32'(e_data));
                        end
                        n_bad++;
                    end
                    if (b == 19202) expect_done = 1'b1;
                    b++;
                end
                tick();
            end
            fill_req = 1'b0;
            write_en = 1'b0;
            check("fill_beat_count", 32'(b), 32'(19204));
            check("fill_bad_beats", 32'(n_bad), 32'(0));
            for (int k = 0; k < 3; k++) begin
                if (fill_done) done_cnt++;
                tick();
            end
            check("fill_done_pulses", 32'(done_cnt), 32'(1));
            check("fill_end_level", 32'(level), 32'(0));
            check("fill_end_wren", 32'(fb_wren), 32'(0));
        end

        // Fill with a toggling ready, a second ignored fill_req, then reset mid-fill.
        begin
            int nfill = 0;
            int n_bad = 0;
            for (int cyc = 0; cyc < 60; cyc++) begin
                fb_ready = cyc[0];
                fill_req = (cyc == 0) || (cyc == 20);
                fill_colour = (cyc == 0) ? 6'h2a : 6'h11;
                write_en = 1'b0;
                if (cyc == 30) put(8'd1, 7'd1, 6'd3);
                if (fb_wren && fb_ready) begin
                    if (fb_addr !== 15'(nfill) || fb_data !== 6'h2a) begin
                        if (n_bad < 4)
                            check($sformatf("tog_beat%0d_addr", nfill), 32'(fb_addr), 32'(nfill));
                        n_bad++;
                    end
                    nfill++;
                end
                tick();
            end
            fill_req = 1'b0;
            write_en = 1'b0;
            check("tog_beats", 32'(nfill), 32'(29));
            check("tog_bad_beats", 32'(n_bad), 32'(0));
            check("tog_level_before_rst", 32'(level), 32'(1));
            check("tog_busy_before_rst", 32'(fill_busy), 32'(1));
            reset_n = 1'b0;
            tick();
            check("midrst_wren", 32'(fb_wren), 32'(0));
            check("midrst_busy", 32'(fill_busy), 32'(0));
            check("midrst_level", 32'(level), 32'(0));
            check("midrst_done", 32'(fill_done), 32'(0));
            reset_n = 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
